// File: rtl/i2c_seq_pkg.sv
// Shared types and constants for the I2C write sequencer: FSM states,
// SSD1306 default address/control bytes and the per-frame byte indices.
package i2c_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_BYTE,
        ST_ACK,
        ST_STOP1,
        ST_STOP2,
        ST_DONE
    } state_e;

    localparam logic [7:0] SSD1306_ADDR      = 8'h78;
    localparam logic [7:0] SSD1306_CTRL_CMD  = 8'h00;
    localparam logic [7:0] SSD1306_CTRL_DATA = 8'hC0;

    // Position of a byte within one address/control/payload frame.
    localparam logic [1:0] BIDX_ADDR = 2'd0;
    localparam logic [1:0] BIDX_CTRL = 2'd1;
    localparam logic [1:0] BIDX_DATA = 2'd2;

endpackage

// File: rtl/i2c_byte_tx.sv
// Bit serialiser for one frame byte: selects address, control or payload
// byte and walks its bits MSB first under load/shift control from the FSM.
module i2c_byte_tx
    import i2c_seq_pkg::*;
#(
    parameter logic [7:0] SLAVE_ADDR = SSD1306_ADDR,
    parameter logic [7:0] CTRL_CMD   = SSD1306_CTRL_CMD,
    parameter logic [7:0] CTRL_DATA  = SSD1306_CTRL_DATA
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       load_i,
    input  logic       shift_i,
    input  logic [1:0] byte_idx_i,
    input  logic       select_i,
    input  logic [7:0] data_i,
    output logic       bit_o,
    output logic       last_bit_o
);

    logic [2:0] bitidx_q, bitidx_d;
    logic [7:0] cur_byte;

    always_comb begin
        bitidx_d = bitidx_q;
        if (load_i) begin
            bitidx_d = 3'd7;
        end else if (shift_i) begin
            bitidx_d = bitidx_q - 3'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bitidx_q <= 3'd7;
        end else begin
            bitidx_q <= bitidx_d;
        end
    end

    always_comb begin
        case (byte_idx_i)
            BIDX_ADDR: cur_byte = SLAVE_ADDR;
            BIDX_CTRL: cur_byte = select_i ? CTRL_DATA : CTRL_CMD;
            default:   cur_byte = data_i;
        endcase
    end

    assign bit_o      = cur_byte[bitidx_q];
    assign last_bit_o = (bitidx_q == 3'd0);

endmodule

// File: rtl/i2c_seq_writer.sv
// I2C write sequencer: streams a command table then a data table, one payload
// byte per transaction. Define I2C_SEQ_RETRY_EN for bounded NACK retry + err.
module i2c_seq_writer
    import i2c_seq_pkg::*;
#(
    parameter logic [7:0] SLAVE_ADDR = SSD1306_ADDR,
    parameter logic [7:0] CTRL_CMD   = SSD1306_CTRL_CMD,
    parameter logic [7:0] CTRL_DATA  = SSD1306_CTRL_DATA,
    parameter int         AW         = 10,
    parameter int         CMD_LEN    = 41,
    parameter int         DATA_LEN   = 1024,
    parameter int         MAX_RETRY  = 3
) (
    input  logic          clk2,
    input  logic          reset,
    input  logic          start,
    input  logic          sda,
    input  logic [7:0]    data,
    output logic [AW-1:0] address,
    output logic          select,
    output logic          sda_w,
    output logic          ctrl_h,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam logic [AW-1:0] CMD_LAST  = AW'(CMD_LEN - 1);
    localparam logic [AW-1:0] DATA_LAST = AW'(DATA_LEN - 1);

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          sel_q, sel_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;
    logic          last_q, last_d;
    logic [1:0]    bidx_q, bidx_d;

    logic tx_load, tx_shift, tx_bit, tx_last_bit;
    logic run_clr, retry_inc, retry_clr, err_set, retry_exh;
    logic phase_last;

    i2c_byte_tx #(
        .SLAVE_ADDR (SLAVE_ADDR),
        .CTRL_CMD   (CTRL_CMD),
        .CTRL_DATA  (CTRL_DATA)
    ) u_byte_tx (
        .clk_i      (clk2),
        .rst_ni     (reset),
        .load_i     (tx_load),
        .shift_i    (tx_shift),
        .byte_idx_i (bidx_q),
        .select_i   (sel_q),
        .data_i     (data),
        .bit_o      (tx_bit),
        .last_bit_o (tx_last_bit)
    );

    assign phase_last = sel_q ? (addr_q == DATA_LAST) : (addr_q == CMD_LAST);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        sel_d     = sel_q;
        done_d    = done_q;
        last_d    = last_q;
        bidx_d    = bidx_q;
        tx_load   = 1'b0;
        tx_shift  = 1'b0;
        run_clr   = 1'b0;
        retry_inc = 1'b0;
        retry_clr = 1'b0;
        err_set   = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_START;
                    addr_d  = '0;
                    sel_d   = 1'b0;
                    done_d  = 1'b0;
                    last_d  = 1'b0;
                    bidx_d  = BIDX_ADDR;
                    tx_load = 1'b1;
                    run_clr = 1'b1;
                end
            end
            ST_START: begin
                state_d = ST_BYTE;
                bidx_d  = BIDX_ADDR;
                tx_load = 1'b1;
            end
            ST_BYTE: begin
                if (tx_last_bit) begin
                    state_d = ST_ACK;
                end else begin
                    tx_shift = 1'b1;
                end
            end
            ST_ACK: begin
                if (sda) begin
                    // NACK: abandon the frame, keep the address, resend later.
                    state_d   = ST_STOP1;
                    last_d    = 1'b0;
                    retry_inc = 1'b1;
                end else if (bidx_q != BIDX_DATA) begin
                    state_d = ST_BYTE;
                    bidx_d  = bidx_q + 2'd1;
                    tx_load = 1'b1;
                end else begin
                    state_d   = ST_STOP1;
                    last_d    = phase_last;
                    retry_clr = 1'b1;
                    if (!phase_last) begin
                        addr_d = addr_q + AW'(1);
                    end
                end
            end
            ST_STOP1: state_d = ST_STOP2;
            ST_STOP2: begin
                if (retry_exh) begin
                    state_d = ST_DONE;
                    err_set = 1'b1;
                end else if (last_q && !sel_q) begin
                    state_d = ST_START;
                    sel_d   = 1'b1;
                    addr_d  = '0;
                    last_d  = 1'b0;
                end else if (last_q) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_START;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
    end

    always_ff @(posedge clk2 or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            sel_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            last_q  <= 1'b0;
            bidx_q  <= BIDX_ADDR;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            sel_q   <= sel_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            last_q  <= last_d;
            bidx_q  <= bidx_d;
        end
    end

`ifdef I2C_SEQ_RETRY_EN
    localparam int RW = $clog2(MAX_RETRY + 1);

    logic [RW-1:0] retry_q, retry_d;
    logic          err_q, err_d;

    always_comb begin
        retry_d = retry_q;
        err_d   = err_q;
        if (run_clr) begin
            retry_d = '0;
            err_d   = 1'b0;
        end else begin
            if (retry_inc) begin
                retry_d = retry_q + RW'(1);
            end else if (retry_clr) begin
                retry_d = '0;
            end
            if (err_set) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk2 or negedge reset) begin
        if (!reset) begin
            retry_q <= '0;
            err_q   <= 1'b0;
        end else begin
            retry_q <= retry_d;
            err_q   <= err_d;
        end
    end

    assign retry_exh = (retry_q == RW'(MAX_RETRY));
    assign err       = err_q;
`else
    // Without the retry counter a NACKed frame is resent forever.
    localparam int unused_max_retry = MAX_RETRY;
    logic unused_retry;
    assign unused_retry = ^{run_clr, retry_inc, retry_clr, err_set};
    assign retry_exh    = 1'b0;
    assign err          = 1'b0;
`endif

    always_comb begin
        sda_w  = 1'b1;
        ctrl_h = 1'b1;
        case (state_q)
            ST_START, ST_STOP1: sda_w = 1'b0;
            ST_BYTE: begin
                sda_w  = tx_bit;
                ctrl_h = 1'b0;
            end
            ST_ACK:  ctrl_h = 1'b0;
            default: ;
        endcase
    end

    assign address = addr_q;
    assign select  = sel_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_i2c_seq_writer.sv
// Bench for i2c_seq_writer: a transaction-level model expands each planned
// I2C frame into expected per-cycle outputs; one process compares every cycle.
module tb_i2c_seq_writer;

    localparam int AW   = 4;
    localparam int CLEN = 2;
    localparam int DLEN = 3;
    localparam int MAXR = 3;
`ifdef I2C_SEQ_RETRY_EN
    localparam bit RETRY = 1'b1;
`else
    localparam bit RETRY = 1'b0;
`endif

    typedef struct packed {
        logic          sda_w;
        logic          ctrl_h;
        logic [AW-1:0] addr;
        logic          sel;
        logic          busy;
        logic          done;
        logic          err;
        logic          sda_in;
    } cyc_t;

    logic          clk2 = 1'b0;
    logic          reset, start, sda;
    logic [7:0]    data;
    logic [AW-1:0] address;
    logic          select, sda_w, ctrl_h, busy, done, err;

    logic [7:0] ctab [16];
    logic [7:0] dtab [16];
    cyc_t       exp_q [$];
    int         popped = 0;
    int         n_cmp  = 0;
    int         n_bad  = 0;
    logic       dut_log [512];

    always #5 clk2 = ~clk2;

    assign data = select ? dtab[address] : ctab[address];

    i2c_seq_writer #(
        .SLAVE_ADDR (8'h78),
        .CTRL_CMD   (8'h00),
        .CTRL_DATA  (8'hC0),
        .AW         (AW),
        .CMD_LEN    (CLEN),
        .DATA_LEN   (DLEN),
        .MAX_RETRY  (MAXR)
    ) dut (
        .clk2    (clk2),
        .reset   (reset),
        .start   (start),
        .sda     (sda),
        .data    (data),
        .address (address),
        .select  (select),
        .sda_w   (sda_w),
        .ctrl_h  (ctrl_h),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, want);
        end
    endtask

    task automatic push(input logic sw, input logic ch, input int a, input logic s,
                        input logic b, input logic d, input logic er, input logic si);
        cyc_t c;
        c.sda_w = sw; c.ctrl_h = ch; c.addr = AW'(a); c.sel = s;
        c.busy = b; c.done = d; c.err = er; c.sda_in = si;
        exp_q.push_back(c);
    endtask

    // One frame: START, up to three 8-bit bytes each followed by an ACK slot,
    // then STOP. nbyte is the byte the slave NACKs (-1 = all acknowledged).
    task automatic push_frame(input int s, input int a, input int nbyte, input int post);
        logic [7:0] v;
        push(1'b0, 1'b1, a, s[0], 1'b1, 1'b0, 1'b0, 1'b1);
        for (int b = 0; b < 3; b++) begin
            if (b == 0)      v = 8'h78;
            else if (b == 1) v = (s != 0) ? 8'hC0 : 8'h00;
            else             v = (s != 0) ? dtab[a] : ctab[a];
            for (int i = 7; i >= 0; i--) push(v[i], 1'b0, a, s[0], 1'b1, 1'b0, 1'b0, 1'b1);
            push(1'b1, 1'b0, a, s[0], 1'b1, 1'b0, 1'b0, (b == nbyte));
            if (b == nbyte) break;
        end
        push(1'b0, 1'b1, post, s[0], 1'b1, 1'b0, 1'b0, 1'b1);
        push(1'b1, 1'b1, post, s[0], 1'b1, 1'b0, 1'b0, 1'b1);
    endtask

    // Whole run: slave NACKs byte nbyte of (nsel,naddr) ntimes times
    // (ntimes < 0: forever). Ends with two cycles of the DONE state.
    task automatic model_run(input int nsel, input int naddr, input int nbyte, input int ntimes);
        int att;
        int len;
        bit nk;
        for (int s = 0; s < 2; s++) begin
            len = (s != 0) ? DLEN : CLEN;
            for (int a = 0; a < len; a++) begin
                att = 0;
                do begin
                    nk = (s == nsel) && (a == naddr) && (ntimes < 0 || att < ntimes);
                    push_frame(s, a, nk ? nbyte : -1, (nk || a == len - 1) ? a : a + 1);
                    att++;
                    if (nk && RETRY && att == MAXR) begin
                        repeat (2) push(1'b1, 1'b1, a, s[0], 1'b0, 1'b0, 1'b1, 1'b1);
                        return;
                    end
                end while (nk);
            end
        end
        repeat (2) push(1'b1, 1'b1, DLEN - 1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    endtask

    function automatic logic [7:0] model_byte(input int i);
        logic [7:0] v;
        for (int k = 0; k < 8; k++) v[7-k] = exp_q[i+k].sda_w;
        return v;
    endfunction

    function automatic logic [7:0] log_byte(input int i);
        logic [7:0] v;
        for (int k = 0; k < 8; k++) v[7-k] = dut_log[i+k];
        return v;
    endfunction

    always @(negedge clk2) begin
        cyc_t e;
        cyc_t a;
        if (exp_q.size() != 0) begin
            e   = exp_q.pop_front();
            sda = e.sda_in;
            a   = {sda_w, ctrl_h, address, select, busy, done, err, e.sda_in};
            if (popped < 512) dut_log[popped] = sda_w;
            n_cmp++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL cycle %0d: got sda_w=%b ctrl_h=%b addr=%0d sel=%b busy=%b done=%b err=%b, expected sda_w=%b ctrl_h=%b addr=%0d sel=%b busy=%b done=%b err=%b",
                         popped, a.sda_w, a.ctrl_h, a.addr, a.sel, a.busy, a.done, a.err,
                         e.sda_w, e.ctrl_h, e.addr, e.sel, e.busy, e.done, e.err);
            end
            popped++;
        end else begin
            sda = 1'b1;
        end
    end

    task automatic kick();
        @(negedge clk2);
        start = 1'b1;
        @(posedge clk2);
        #1;
        start  = 1'b0;
        popped = 0;
    endtask

    // Wait for the expected stream to drain; optionally pulse start mid-run.
    task automatic drain(input int budget, input int pulse_at, input string name);
        int  k = 0;
        bit  pulsed = 1'b0;
        while (exp_q.size() != 0 && k < budget) begin
            @(posedge clk2);
            #1;
            k++;
            start = 1'b0;
            if (pulse_at >= 0 && !pulsed && popped >= pulse_at) begin
                start  = 1'b1;
                pulsed = 1'b1;
            end
        end
        start = 1'b0;
        chk({name, " pending entries"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        int k;
        for (int i = 0; i < 16; i++) begin
            ctab[i] = 8'h00;
            dtab[i] = 8'h00;
        end
        ctab[0] = 8'hA5; ctab[1] = 8'h3C;
        dtab[0] = 8'h81; dtab[1] = 8'h7E; dtab[2] = 8'h5A;
        start = 1'b0;
        sda   = 1'b1;
        reset = 1'b0;

        repeat (3) @(posedge clk2);
        #1;
        chk("reset sda_w",   sda_w,   1);
        chk("reset ctrl_h",  ctrl_h,  1);
        chk("reset address", address, 0);
        chk("reset select",  select,  0);
        chk("reset busy",    busy,    0);
        chk("reset done",    done,    0);
        chk("reset err",     err,     0);
        reset = 1'b1;
        repeat (2) @(posedge clk2);
        #1;
        chk("idle busy", busy, 0);

        // Clean run, with a start pulse while busy that must be ignored.
        kick();
        model_run(-1, -1, -1, 0);
        chk("model clean length", exp_q.size(), 152);
        chk("model done at 150", {exp_q[149].busy, exp_q[150].busy, exp_q[150].done}, 3'b101);
        chk("model cmd addr byte", model_byte(1), 8'h78);
        chk("model cmd ctrl byte", model_byte(10), 8'h00);
        chk("model data ctrl byte", model_byte(70), 8'hC0);
        drain(400, 40, "clean run");
        chk("dut frame0 addr byte", log_byte(1), 8'h78);
        chk("dut frame0 ctrl byte", log_byte(10), 8'h00);
        chk("dut frame0 payload",   log_byte(19), 8'hA5);
        chk("dut data frame addr",  log_byte(61), 8'h78);
        chk("dut data frame ctrl",  log_byte(70), 8'hC0);
        chk("dut data frame payload", log_byte(79), 8'h81);

        // Restart from DONE; one NACK on the payload of command 1.
        kick();
        model_run(0, 1, 2, 1);
        chk("model nack length", exp_q.size(), 182);
        drain(400, -1, "nack run");

        if (RETRY) begin
            kick();
            model_run(0, 0, 0, -1);
            chk("model retry length", exp_q.size(), 3 * 12 + 2);
            drain(200, -1, "retry run");
            #1;
            chk("retry err",  err,  1);
            chk("retry done", done, 0);
            chk("retry busy", busy, 0);
        end

        // Reset during a BYTE cycle of data transaction 1.
        kick();
        model_run(-1, -1, -1, 0);
        k = 0;
        while (popped < 94 && k < 500) begin
            @(posedge clk2);
            k++;
        end
        chk("reach data byte", (popped >= 94), 1);
        #1;
        reset = 1'b0;
        exp_q.delete();
        @(negedge clk2);
        chk("midrun reset sda_w",   sda_w,   1);
        chk("midrun reset ctrl_h",  ctrl_h,  1);
        chk("midrun reset address", address, 0);
        chk("midrun reset select",  select,  0);
        chk("midrun reset busy",    busy,    0);
        reset = 1'b1;
        repeat (2) @(posedge clk2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/i2c_seq_writer.md
# i2c_seq_writer

Parametrised I2C write sequencer that streams a command table followed by a data table to one slave, one payload byte per I2C transaction (address byte, control byte, payload byte). It sits between the table ROM (addressed via `address`/`data`) and the bit-clock generator that drives SCL from `ctrl_h`. It extends the free-running OLED init/refresh controller with a start/busy/done handshake, configurable table lengths and control bytes, and bounded NACK retry with an error flag.

## Interface
- SLAVE_ADDR, 8'h78, 8-bit write-form slave address byte.
- CTRL_CMD, 8'h00, control byte sent during the command phase.
- CTRL_DATA, 8'hC0, control byte sent during the data phase.
- CMD_LEN, 41, command-table entries; 1..2^AW.
- DATA_LEN, 1024, data-table entries; 1..2^AW.
- AW, 10, table address width.
- MAX_RETRY, 3, NACK retries per transaction (retry build only); ≥1.
- clk2  in  1  sole clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; honoured only when busy=0.
- sda  in  1  SDA line as read back from the bus.
- data  in  8  table byte at `address`; stable while `address` is stable.
- address  out  AW  table index of the current payload.
- select  out  1  0 = command phase, 1 = data phase.
- sda_w  out  1  SDA drive value (1 = release).
- ctrl_h  out  1  1 = hold SCL high; 0 = SCL toggles one bit per cycle.
- busy  out  1  run in progress.
- done  out  1  run finished; sticky until next accepted start.
- err  out  1  run aborted on retry exhaustion; sticky until next accepted start.

## Operation
- States: IDLE, START, BYTE, ACK, STOP1, STOP2, DONE.
- IDLE/DONE: sda_w=1, ctrl_h=1. start → clear address, select, err, retry, byte index, bit index; go START.
- START: sda_w=0, ctrl_h=1 → BYTE, bit index 7, byte index 0.
- BYTE: ctrl_h=0; sda_w = bit[bitidx] of byte 0 SLAVE_ADDR, byte 1 CTRL_CMD/CTRL_DATA by select, byte 2 `data`; MSB first. bitidx 0 → ACK, else decrement.
- ACK: sda_w=1, ctrl_h=0; ack = sda at the edge leaving ACK (0 = ACK).
  - ACK on bytes 0,1 → BYTE, next byte, bitidx 7.
  - ACK on byte 2 → STOP1; last = (address == LEN−1) for current phase; address increments modulo 2^AW unless last; retry cleared.
  - NACK → STOP1, address unchanged, retry+1, same transaction resent.
- STOP1: sda_w=0, ctrl_h=1 → STOP2.
- STOP2: sda_w=1, ctrl_h=1. Retry exhausted → DONE with err=1. Else last & select=0 → select=1, address=0, START. Else last & select=1 → DONE, done=1. Else → START.
- busy=1 in every state except IDLE and DONE.
- start while busy: ignored. start in DONE: new run, done/err cleared.
- reset mid-run: immediate IDLE, sda_w=1, ctrl_h=1; no STOP issued.

## Timing
- Reset values: state IDLE, address 0, select 0, sda_w 1, ctrl_h 1, busy 0, done 0, err 0.
- sda_w/ctrl_h are decoded from the registered state; address/select/done/err/busy are registered.
- start sampled at edge N → START during cycle N+1.
- Transaction: 1 START + 3×(8+1) + 2 STOP = 30 cycles; STOP2 → START back-to-back.
- Clean run: (CMD_LEN+DATA_LEN)×30 cycles from START to DONE; done high the cycle after the final STOP2.

## Configuration
- I2C_SEQ_RETRY_EN defined: retry counter of width clog2(MAX_RETRY+1); the MAX_RETRY-th consecutive NACK on one transaction ends the run with err=1.
- Undefined: NACK always resends the same transaction indefinitely; err is tied to 0; MAX_RETRY is unused.

## Structure
- Package i2c_seq_pkg: state enum, SSD1306 defaults (8'h78, 8'h00, 8'hC0), byte-index constants.
- One sub-module, i2c_byte_tx: bit-index counter plus MSB-first byte mux, with `load`/`last_bit` handshake to the FSM.

## Test plan
- CMD_LEN=2, DATA_LEN=3, slave always ACKs, start pulse → 5 transactions, addresses 0,1 (select 0) then 0,1,2 (select 1), done after 150 cycles, err 0.
- Byte content check → first frame serialises 0x78, 0x00, data[0]; first data-phase frame serialises 0x78, 0xC0.
- Single NACK on payload of command 1 → STOP, same transaction resent with address 1, run completes, err 0.
- Retry build, MAX_RETRY=3, slave permanently NACKs address byte → 3 attempts, DONE with err=1, done=0, busy=0.
- start pulsed while busy → ignored; start in DONE → done/err clear, address 0, select 0, new run.
- reset asserted during BYTE of data transaction → next cycle sda_w=1, ctrl_h=1, address 0, busy 0.
